pwm_duty_meter: RTL and testbench

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive side of the PWM generator: it closes the loop on the duty-cycle output, either on-chip or on a second die, and gives a checkable readback of the duty step. It also flags 0 %/100 % (edge-less) signals and periods that deviate from nominal.

---
 rtl/pwm_duty_meter.sv | 151 +++++++++++++++
 tb/tb_pwm_duty_meter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM receive-side meter: measures high time and period of pwm_in in clk cycles,
// flags edge-less (stuck) inputs and off-nominal periods.
module pwm_duty_meter #(
    parameter int CLK_PER_PERIOD = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int CW             = $clog2(2*CLK_PER_PERIOD+1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pwm_in,
    output logic [CW-1:0] duty_out,
    output logic [CW-1:0] period_out,
    output logic          valid_out,
    output logic          stuck_out,
    output logic          period_err_out
);

    localparam logic [CW-1:0] TIMEOUT = CW'(2*CLK_PER_PERIOD);
    localparam logic [CW-1:0] NOMINAL = CW'(CLK_PER_PERIOD);

    typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic [CW-1:0]          per_cnt_q, per_cnt_d;
    logic [CW-1:0]          hi_cnt_q, hi_cnt_d;
    logic [CW-1:0]          duty_q, duty_d;
    logic [CW-1:0]          period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;
    logic                   err_q, err_d;
    logic                   s, rise, timeout;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign timeout = (per_cnt_q == TIMEOUT);

    // Synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= s;
        end
    end

    // Both counters restart at 1 on a rise: the rise cycle itself is high
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = CW'(1);
            hi_cnt_d  = CW'(1);
        end else begin
            if (per_cnt_q != TIMEOUT)
                per_cnt_d = per_cnt_q + 1'b1;
            if (s && hi_cnt_q != TIMEOUT)
                hi_cnt_d = hi_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A rise always beats a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, MEASURE: begin
                if (rise)         state_d = MEASURE;
                else if (timeout) state_d = STUCK;
            end
            STUCK:   if (rise) state_d = MEASURE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        duty_d   = duty_q;
        period_d = period_q;
        err_d    = err_q;
        stuck_d  = stuck_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rise && timeout) begin
                    stuck_d  = 1'b1;
                    period_d = '0;
                    err_d    = 1'b0;
                    duty_d   = s ? NOMINAL : '0;
                    valid_d  = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = per_cnt_q;
                    duty_d   = hi_cnt_q;
                    err_d    = (per_cnt_q != NOMINAL);
                    valid_d  = 1'b1;
                end else if (timeout) begin
                    stuck_d  = 1'b1;
                    period_d = '0;
                    err_d    = 1'b0;
                    duty_d   = s ? NOMINAL : '0;
                    valid_d  = 1'b1;
                end
            end
            // Interval ending in the resuming rise is not a real period
            STUCK: if (rise) stuck_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            err_q    <= err_d;
        end
    end

    assign duty_out       = duty_q;
    assign period_out     = period_q;
    assign valid_out      = valid_q;
    assign stuck_out      = stuck_q;
    assign period_err_out = err_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: table-driven waveform cases with hand-derived results,
// hand sequences for step/resume/reset, and random waveforms against an event-level model.
module tb_pwm_duty_meter;

    localparam int CPP  = 10;
    localparam int SS   = 2;
    localparam int CW   = $clog2(2*CPP+1);
    localparam int T    = 2*CPP;
    localparam int MAXN = 512;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] duty_out, period_out;
    logic          valid_out, stuck_out, period_err_out;

    always #5 clk = ~clk;

    pwm_duty_meter #(.CLK_PER_PERIOD(CPP), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
        .duty_out(duty_out), .period_out(period_out), .valid_out(valid_out),
        .stuck_out(stuck_out), .period_err_out(period_err_out)
    );

    int tests = 0;
    int fails = 0;

    bit p [0:MAXN];
    int n;
    int e_duty [0:MAXN];
    int e_per  [0:MAXN];
    bit e_val  [0:MAXN];
    bit e_stk  [0:MAXN];
    bit e_err  [0:MAXN];

    typedef struct {
        int hi, lo, reps;
        int duty, per;
        bit err, stk;
        int nval, fv;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_wave();
        n = 0;
    endtask

    task automatic add_seg(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) if (n < MAXN) begin n++; p[n] = 1'b1; end
            for (int i = 0; i < lo; i++) if (n < MAXN) begin n++; p[n] = 1'b0; end
        end
    endtask

    // Synchronized level seen after edge k: pwm delayed by the synchronizer depth
    function automatic bit s_at(input int k);
        if (k - SS + 1 < 1) return 1'b0;
        return p[k - SS + 1];
    endfunction

    // Event-level model: a period is the distance between successive rises,
    // high time is the number of high samples in it, stuck after T edge-less cycles.
    function automatic void build_model();
        int anchor = 0;
        bit armed = 0, stuck = 0, err = 0;
        int duty = 0, per = 0, cnt;
        bit rise, val;
        e_duty[0] = 0; e_per[0] = 0; e_val[0] = 0; e_stk[0] = 0; e_err[0] = 0;
        for (int e = 0; e < n; e++) begin
            rise = s_at(e) && !s_at(e-1);
            val  = 1'b0;
            if (rise) begin
                if (armed) begin
                    per = (e - anchor > T) ? T : e - anchor;
                    cnt = 0;
                    for (int j = anchor; j < e; j++) cnt += int'(s_at(j));
                    duty = (cnt > T) ? T : cnt;
                    err  = (per != CPP);
                    val  = 1'b1;
                end
                armed  = 1'b1;
                stuck  = 1'b0;
                anchor = e;
            end else if (!stuck && (e - anchor) >= T) begin
                stuck = 1'b1;
                armed = 1'b0;
                per   = 0;
                err   = 1'b0;
                duty  = s_at(e) ? CPP : 0;
                val   = 1'b1;
            end
            e_duty[e+1] = duty; e_per[e+1] = per; e_val[e+1] = val;
            e_stk[e+1]  = stuck; e_err[e+1] = err;
        end
    endfunction

    task automatic run_seq(input string tag, output int nval, output int first_v);
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        build_model();
        nval    = 0;
        first_v = -1;
        for (int k = 1; k <= n; k++) begin
            pwm_in = p[k];
            @(posedge clk);
            #1;
            tests++;
            if (duty_out !== e_duty[k][CW-1:0] || period_out !== e_per[k][CW-1:0] ||
                valid_out !== e_val[k] || stuck_out !== e_stk[k] || period_err_out !== e_err[k]) begin
                fails++;
                $display("FAIL %s edge %0d: got d=%0d p=%0d v=%b s=%b e=%b expected d=%0d p=%0d v=%b s=%b e=%b",
                         tag, k, duty_out, period_out, valid_out, stuck_out, period_err_out,
                         e_duty[k], e_per[k], e_val[k], e_stk[k], e_err[k]);
            end
            if (valid_out === 1'b1) begin
                nval++;
                if (first_v < 0) first_v = k;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int nv, fv;
        string nm;

        //          hi  lo reps duty per err stk nval fv
        tbl[0] = '{ 5,  5, 4,   5,  10, 0,  0,  3,   13};
        tbl[1] = '{ 6,  6, 4,   6,  12, 1,  0,  3,   15};
        tbl[2] = '{ 4,  6, 3,   4,  10, 0,  0,  2,   13};
        tbl[3] = '{30,  0, 1,  10,   0, 0,  1,  1,   23};
        tbl[4] = '{ 0, 30, 1,   0,   0, 0,  1,  1,   21};
        tbl[5] = '{10, 10, 3,  10,  20, 1,  0,  2,   23};
        tbl[6] = '{10, 11, 3,   0,   0, 0,  0,  2,   23};

        // Reset state
        reset_n = 1'b0;
        #12;
        chk("reset duty", int'(duty_out), 0);
        chk("reset period", int'(period_out), 0);
        chk("reset flags", int'({valid_out, stuck_out, period_err_out}), 0);

        for (int i = 0; i < 7; i++) begin
            nm = $sformatf("tbl%0d", i);
            clear_wave();
            add_seg(tbl[i].hi, tbl[i].lo, tbl[i].reps);
            run_seq(nm, nv, fv);
            chk({nm, " duty"}, int'(duty_out), tbl[i].duty);
            chk({nm, " period"}, int'(period_out), tbl[i].per);
            chk({nm, " err"}, int'(period_err_out), int'(tbl[i].err));
            chk({nm, " stuck"}, int'(stuck_out), int'(tbl[i].stk));
            chk({nm, " nvalid"}, nv, tbl[i].nval);
            chk({nm, " first valid edge"}, fv, tbl[i].fv);
        end

        // Duty step 3 -> 7 mid-stream
        clear_wave();
        add_seg(3, 7, 3);
        add_seg(7, 3, 3);
        run_seq("step", nv, fv);
        chk("step duty", int'(duty_out), 7);
        chk("step period", int'(period_out), 10);
        chk("step nvalid", nv, 5);

        // Stuck low, then 40 % PWM resumes: resume rise gives no valid
        clear_wave();
        add_seg(0, 30, 1);
        add_seg(4, 6, 3);
        run_seq("resume", nv, fv);
        chk("resume duty", int'(duty_out), 4);
        chk("resume period", int'(period_out), 10);
        chk("resume stuck", int'(stuck_out), 0);
        chk("resume nvalid", nv, 3);

        // Asynchronous reset mid-period
        clear_wave();
        add_seg(5, 5, 3);
        run_seq("prereset", nv, fv);
        @(posedge clk);
        chk("prereset duty", int'(duty_out), 5);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset duty", int'(duty_out), 0);
        chk("async reset period", int'(period_out), 0);
        chk("async reset flags", int'({valid_out, stuck_out, period_err_out}), 0);

        // Random waveforms including long gaps
        for (int r = 0; r < 12; r++) begin
            int hi, lo;
            clear_wave();
            while (n < 300) begin
                hi = $urandom_range(0, 14);
                lo = $urandom_range(0, 14);
                if ($urandom_range(0, 9) == 0) hi += $urandom_range(15, 25);
                if ($urandom_range(0, 9) == 0) lo += $urandom_range(15, 25);
                if (hi + lo > 0) add_seg(hi, lo, $urandom_range(1, 4));
            end
            run_seq($sformatf("rand%0d", r), nv, fv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
